// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the 6809 interrupt arbiter slice:
//   - interrupt source IDs (UART, CH375, RTC)
//   - register offsets inside the arbiter's I/O slot
//   - arbiter state encoding
//   - arbitration helpers (fixed priority and round-robin search)
// -----------------------------------------------------------------------------
package irq_pkg;

  // Interrupt source IDs; ID 3 is never produced by the arbitration helpers.
  localparam logic [1:0] SRC_UART = 2'd0;
  localparam logic [1:0] SRC_CH   = 2'd1;
  localparam logic [1:0] SRC_RTC  = 2'd2;

  // Register offsets.
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_MASK   = 2'd1;
  localparam logic [1:0] REG_VECTOR = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } irq_state_t;

  // Next source ID in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] next_src(input logic [1:0] id);
    logic [1:0] nxt;
    case (id)
      SRC_UART: nxt = SRC_CH;
      SRC_CH:   nxt = SRC_RTC;
      default:  nxt = SRC_UART;
    endcase
    return nxt;
  endfunction

  // Pick the winning source. Round-robin starts the search one past the
  // last-grant pointer; fixed priority is RTC > UART > CH375 and ignores it.
  // With no request the result is don't-care and defaults to UART.
  function automatic logic [1:0] arb_pick(input logic [2:0] req,
                                          input logic [1:0] last_ptr,
                                          input logic       rr_en);
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] pick;
    c0 = next_src(last_ptr);
    c1 = next_src(c0);
    c2 = next_src(c1);
    if (rr_en) begin
      if (req[c0])      pick = c0;
      else if (req[c1]) pick = c1;
      else if (req[c2]) pick = c2;
      else              pick = SRC_UART;
    end else begin
      if (req[SRC_RTC])       pick = SRC_RTC;
      else if (req[SRC_UART]) pick = SRC_UART;
      else if (req[SRC_CH])   pick = SRC_CH;
      else                    pick = SRC_UART;
    end
    return pick;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// -----------------------------------------------------------------------------
// irq_sync
// Multi-flop synchronizer for one active-low interrupt line. All stages reset
// to 1 so the line reads inactive straight out of reset.
// Ports:
//   i_eclk   - E clock
//   i_reset  - asynchronous active-low reset
//   din      - raw interrupt line (active-low)
//   dout     - synchronized line (active-low)
// -----------------------------------------------------------------------------
module irq_sync #(
  parameter int DEPTH = 2
) (
  input  logic i_eclk,
  input  logic i_reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_r;

  // Shift the raw line through DEPTH flops.
  always_ff @(posedge i_eclk or negedge i_reset) begin
    if (!i_reset) begin
      sr_r <= {DEPTH{1'b1}};
    end else begin
      sr_r <= {sr_r[DEPTH-2:0], din};
    end
  end

  assign dout = sr_r[DEPTH-1];

endmodule

// File: rtl/irq_arbiter.sv
// -----------------------------------------------------------------------------
// irq_arbiter
// Merges three active-low interrupt sources (UART=0, CH375=1, RTC=2) onto the
// 6809 IRQ line and exposes STATUS / MASK / VECTOR registers. Reading VECTOR
// while an interrupt is presented acknowledges it.
// Build option:
//   IRQ_ROUND_ROBIN_EN - round-robin arbitration starting after the last
//                        completed grant; otherwise fixed RTC > UART > CH375.
// Ports:
//   i_eclk     - 6809 E clock, all state changes on its rising edge
//   i_reset    - asynchronous active-low reset
//   i_uartirq  - UART interrupt, active-low
//   i_chirq    - CH375 interrupt, active-low
//   i_rtcirq   - RTC interrupt, active-low
//   i_sel      - register select from the address decoder
//   i_rw       - 6809 R/W, 1 = read
//   i_addr     - register offset
//   i_data     - write data
//   o_data     - read data, 8'h00 unless selected for read
//   irq_n      - merged interrupt to the CPU, active-low
// -----------------------------------------------------------------------------
module irq_arbiter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_eclk,
  input  logic       i_reset,
  input  logic       i_uartirq,
  input  logic       i_chirq,
  input  logic       i_rtcirq,
  input  logic       i_sel,
  input  logic       i_rw,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       irq_n
);

  import irq_pkg::*;

`ifdef IRQ_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic [2:0]  sync_s;
  logic [2:0]  req_s;
  logic [2:0]  mask_r;
  logic [1:0]  grant_id_r;
  logic [1:0]  last_ptr_r;
  logic [1:0]  winner_s;
  irq_state_t  state_r;
  logic        irq_n_r;
  logic        wr_mask_s;
  logic        ack_s;
  logic        grant_live_s;
  logic        unused_data_s;

  irq_sync #(.DEPTH(SYNC_STAGES)) u_sync_uart (
    .i_eclk  (i_eclk),
    .i_reset (i_reset),
    .din     (i_uartirq),
    .dout    (sync_s[SRC_UART])
  );

  irq_sync #(.DEPTH(SYNC_STAGES)) u_sync_ch (
    .i_eclk  (i_eclk),
    .i_reset (i_reset),
    .din     (i_chirq),
    .dout    (sync_s[SRC_CH])
  );

  irq_sync #(.DEPTH(SYNC_STAGES)) u_sync_rtc (
    .i_eclk  (i_eclk),
    .i_reset (i_reset),
    .din     (i_rtcirq),
    .dout    (sync_s[SRC_RTC])
  );

  // Synced lines are active-low; a request is an active, unmasked source.
  assign req_s         = ~sync_s & mask_r;
  assign winner_s      = arb_pick(req_s, last_ptr_r, RR_EN);
  assign grant_live_s  = req_s[grant_id_r];
  assign wr_mask_s     = i_sel & ~i_rw & (i_addr == REG_MASK);
  assign ack_s         = i_sel & i_rw & (i_addr == REG_VECTOR);
  // Only the low three MASK bits exist.
  assign unused_data_s = ^i_data[7:3];
  assign irq_n         = irq_n_r;

  // MASK register; writes to every other offset are dropped.
  always_ff @(posedge i_eclk or negedge i_reset) begin
    if (!i_reset) begin
      mask_r <= 3'b000;
    end else if (wr_mask_s) begin
      mask_r <= i_data[2:0];
    end else begin
      mask_r <= mask_r;
    end
  end

  // Grant state machine with registered irq_n. Acknowledge wins over a
  // same-edge withdrawal because it is tested first in GRANT.
  always_ff @(posedge i_eclk or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= ST_IDLE;
      grant_id_r <= SRC_UART;
      last_ptr_r <= SRC_RTC;
      irq_n_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req_s) begin
            grant_id_r <= winner_s;
            state_r    <= ST_GRANT;
            irq_n_r    <= 1'b0;
          end else begin
            irq_n_r    <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (ack_s) begin
            state_r <= ST_RELEASE;
            irq_n_r <= 1'b1;
          end else if (!grant_live_s) begin
            // Withdrawn before service: pointer deliberately left alone.
            state_r <= ST_IDLE;
            irq_n_r <= 1'b1;
          end else begin
            irq_n_r <= 1'b0;
          end
        end
        ST_RELEASE: begin
          irq_n_r <= 1'b1;
          if (!grant_live_s) begin
            state_r    <= ST_IDLE;
            last_ptr_r <= grant_id_r;
          end else begin
            state_r    <= ST_RELEASE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          irq_n_r <= 1'b1;
        end
      endcase
    end
  end

  // Register read mux; VECTOR only carries a vector while an IRQ is presented.
  always_comb begin
    o_data = 8'h00;
    if (i_sel && i_rw) begin
      case (i_addr)
        REG_STATUS: o_data = {5'b00000, req_s};
        REG_MASK:   o_data = {5'b00000, mask_r};
        REG_VECTOR: begin
          if (state_r == ST_GRANT) begin
            o_data = {1'b1, 5'b00000, grant_id_r};
          end else begin
            o_data = 8'h00;
          end
        end
        default:    o_data = 8'h00;
      endcase
    end else begin
      o_data = 8'h00;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_irq_arbiter
// Directed bench for irq_arbiter (default SYNC_STAGES = 2). Expected values are
// queued as each stimulus step is driven and popped when the DUT output is
// sampled. Expectations that depend on the arbitration build follow
// IRQ_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_irq_arbiter;

  logic       i_eclk = 1'b0;
  logic       i_reset;
  logic       i_uartirq;
  logic       i_chirq;
  logic       i_rtcirq;
  logic       i_sel;
  logic       i_rw;
  logic [1:0] i_addr;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       irq_n;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];

`ifdef IRQ_ROUND_ROBIN_EN
  localparam logic [7:0] VEC_AFTER_UART = 8'h81;
`else
  localparam logic [7:0] VEC_AFTER_UART = 8'h80;
`endif

  always #5 i_eclk = ~i_eclk;

  irq_arbiter #(.SYNC_STAGES(2)) dut (
    .i_eclk    (i_eclk),
    .i_reset   (i_reset),
    .i_uartirq (i_uartirq),
    .i_chirq   (i_chirq),
    .i_rtcirq  (i_rtcirq),
    .i_sel     (i_sel),
    .i_rw      (i_rw),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .o_data    (o_data),
    .irq_n     (irq_n)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_eclk);
      #1;
    end
  endtask

  task automatic expect_val(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp_v;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic check_irq(input string tag, input logic exp_bit);
    expect_val({7'b0000000, exp_bit});
    check(tag, {7'b0000000, irq_n});
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [7:0] data);
    i_sel  = 1'b1;
    i_rw   = 1'b0;
    i_addr = addr;
    i_data = data;
    tick(1);
    i_sel  = 1'b0;
    i_rw   = 1'b1;
  endtask

  // Read is sampled mid-cycle, then the edge that completes the access.
  task automatic read_chk(input string tag, input logic [1:0] addr, input logic [7:0] exp_v);
    i_sel  = 1'b1;
    i_rw   = 1'b1;
    i_addr = addr;
    expect_val(exp_v);
    #1;
    check(tag, o_data);
    tick(1);
    i_sel  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset   = 1'b0;
    i_uartirq = 1'b1;
    i_chirq   = 1'b1;
    i_rtcirq  = 1'b1;
    i_sel     = 1'b0;
    i_rw      = 1'b1;
    i_addr    = 2'd0;
    i_data    = 8'h00;
    tick(2);

    // Reset state.
    check_irq("reset_irq_n", 1'b1);
    read_chk("reset_mask", 2'd1, 8'h00);
    read_chk("reset_status", 2'd0, 8'h00);
    i_reset = 1'b1;
    tick(1);

    // UART alone: three-edge latency, vector 0x80, irq_n high after ack.
    write_reg(2'd1, 8'hFF);
    read_chk("mask_readback", 2'd1, 8'h07);
    i_uartirq = 1'b0;
    tick(1);
    check_irq("uart_lat_edge1", 1'b1);
    tick(1);
    check_irq("uart_lat_edge2", 1'b1);
    tick(1);
    check_irq("uart_lat_edge3", 1'b0);
    read_chk("vec_uart", 2'd2, 8'h80);
    check_irq("uart_ack_irq_n", 1'b1);
    read_chk("vec_release", 2'd2, 8'h00);
    i_uartirq = 1'b1;
    tick(4);
    read_chk("vec_idle", 2'd2, 8'h00);
    read_chk("rsvd_read", 2'd3, 8'h00);

    // RTC masked, then unmasked while already synchronized.
    write_reg(2'd1, 8'h03);
    i_rtcirq = 1'b0;
    tick(4);
    check_irq("rtc_masked_irq_n", 1'b1);
    read_chk("rtc_masked_status", 2'd0, 8'h00);
    write_reg(2'd1, 8'h07);
    check_irq("rtc_unmask_edge0", 1'b1);
    tick(1);
    check_irq("rtc_unmask_edge1", 1'b0);
    read_chk("rtc_status", 2'd0, 8'h04);
    i_sel  = 1'b0;
    i_rw   = 1'b1;
    i_addr = 2'd2;
    expect_val(8'h00);
    #1;
    check("vec_unselected", o_data);
    read_chk("vec_rtc", 2'd2, 8'h82);
    i_rtcirq = 1'b1;
    tick(4);

    // UART and CH375 together; UART pulses high for one cycle after its ack.
    i_uartirq = 1'b0;
    i_chirq   = 1'b0;
    tick(3);
    check_irq("pair_irq_n", 1'b0);
    read_chk("vec_pair_first", 2'd2, 8'h80);
    i_uartirq = 1'b1;
    tick(1);
    i_uartirq = 1'b0;
    tick(3);
    check_irq("pair_regrant_irq_n", 1'b0);
    read_chk("vec_pair_second", 2'd2, VEC_AFTER_UART);
    i_uartirq = 1'b1;
    i_chirq   = 1'b1;
    tick(4);

    // CH375 withdraws while granted.
    i_chirq = 1'b0;
    tick(3);
    check_irq("ch_grant_irq_n", 1'b0);
    i_chirq = 1'b1;
    tick(2);
    check_irq("ch_withdraw_edge2", 1'b0);
    tick(1);
    check_irq("ch_withdraw_edge3", 1'b1);
    read_chk("vec_after_withdraw", 2'd2, 8'h00);

    // All three low: RTC wins; async reset while granted.
    i_uartirq = 1'b0;
    i_chirq   = 1'b0;
    i_rtcirq  = 1'b0;
    tick(3);
    check_irq("all_grant_irq_n", 1'b0);
    i_sel  = 1'b1;
    i_rw   = 1'b1;
    i_addr = 2'd2;
    expect_val(8'h82);
    #1;
    check("vec_all", o_data);
    #1;
    i_reset = 1'b0;
    i_sel   = 1'b0;
    #1;
    check_irq("reset_async_irq_n", 1'b1);
    i_sel  = 1'b1;
    i_addr = 2'd1;
    expect_val(8'h00);
    #1;
    check("reset_async_mask", o_data);
    i_sel = 1'b0;
    tick(1);
    i_reset = 1'b1;
    tick(3);
    check_irq("post_reset_irq_n", 1'b1);
    read_chk("post_reset_status", 2'd0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
